// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the iteration counter width helper.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore result signs.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// with a single start/done handshake and HI/LO result registers.
//
// state   | meaning
// IDLE    | waiting for start; operands and signs latched on accept
// CALC    | one shift-add or restoring-divide step per cycle
// FIX     | restore result signs from the latched sign flags
// DONE    | done pulse; hi/lo/div_zero loaded on entry
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_div;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_signed;
    logic                 w_is_div;
    logic                 w_div0;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_div0   = w_is_div && (b == '0);

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (a),
        .i_neg (w_signed & a[WIDTH-1]),
        .o_val (w_a_mag)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (b),
        .i_neg (w_signed & b[WIDTH-1]),
        .o_val (w_b_mag)
    );

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: partial remainder in the high half, dividend shifts out of the
    // low half while quotient bits shift in. Bit WIDTH of the diff is the borrow.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_val (r_acc),
        .i_neg (r_neg_res),
        .o_val (w_prod_fix)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .i_val (r_acc[WIDTH-1:0]),
        .i_neg (r_neg_res),
        .o_val (w_quo_fix)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (r_acc[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_rem),
        .o_val (w_rem_fix)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_div0 ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed & a[WIDTH-1];
                        r_cnt     <= CW'(WIDTH - 1);
                        if (w_is_div) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opnd <= w_a_mag;
                        end
                        if (w_div0) begin
                            hi       <= a;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end else begin
                        hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo <= w_prod_fix[WIDTH-1:0];
                    end
                    div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit for the multicycle CPU datapath. It replaces the separate fixed-width multiplier and divider with one block that has one start/done handshake and one set of HI/LO result outputs. It supports signed and unsigned MULT and DIV, flags division by zero, and computes the operand width as a parameter. The control unit starts an operation and stalls until `done`, then writes `hi`/`lo` into the HI and LO registers.

## Interface
- `WIDTH`, default 32: operand width; `hi` and `lo` are each `WIDTH` bits; must be ≥ 4.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `hi`/`lo`/`div_zero` are valid from this cycle.
- `hi`  out  WIDTH  product upper half, or remainder.
- `lo`  out  WIDTH  product lower half, or quotient.
- `div_zero`  out  1  last DIV/DIVU had `b` = 0; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start` = 1 latches `op`, |a|, |b| and the result signs. Magnitudes apply to signed ops only; unsigned ops use the raw values.
  - Next state is CALC and the iteration counter loads `WIDTH-1`.
  - Exception: DIV/DIVU with `b` = 0 goes directly to DONE.
- CALC, multiply: radix-2 shift-add, one bit per cycle over a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC exits to FIX when the counter reaches 0. The counter wraps from 0 back to `WIDTH-1` only on a new start.
- FIX:
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign, so the quotient truncates toward zero.
  - Unsigned ops pass through unchanged.
- DONE: `done` = 1 and the result registers are loaded on entry. Next state is IDLE unconditionally.
- Divide by zero: `hi` = `a` (raw), `lo` = all ones, `div_zero` = 1. On every other completion `div_zero` = 0.
- Signed overflow (DIV of the most-negative value by −1): `lo` = the most-negative value and `hi` = 0. There is no flag; this is the natural two's-complement wrap.
- `start` outside IDLE is ignored, including in DONE. Operands need only be stable on the accepting edge.
- `hi`/`lo` hold their values until the next DONE.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `div_zero` 0, internal accumulators 0.
- Reset asserted mid-operation aborts immediately with no `done` pulse.
- Edge E0 accepts `start`, and `busy` rises after E0.
- Normal operation: CALC occupies WIDTH cycles, FIX one cycle, then DONE.
  - `done` is high in the cycle after edge E0+WIDTH+1.
  - Latency from `start` to `done` is WIDTH+2 cycles; 34 cycles at WIDTH = 32.
- Divide by zero: `done` is high in the cycle after E0; latency is 1 cycle.
- Earliest next accept is the IDLE cycle after DONE, giving a throughput of one op per WIDTH+3 cycles.
- `done` and `busy` are both high during DONE.

## Structure
- Package `mult_div_pkg`: `op` encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum, and the counter width `$clog2(WIDTH)`.
- One sub-module, `md_sign_fix`: a combinational, WIDTH-parametrised conditional two's-complement negate. It is instantiated for the operand magnitudes and for the FIX stage.
- The state machine, counter and datapath live in `mult_div_unit`.

## Test plan
- WIDTH = 32, MULT with `a` = 0xFFFFFFFD (−3), `b` = 7:
  - `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
  - `done` arrives exactly 34 cycles after `start`; `busy` is high throughout.
- MULTU with `a` = 0xFFFFFFFF, `b` = 2 → `hi` = 0x00000001, `lo` = 0xFFFFFFFE.
- DIV with `a` = −7, `b` = 2 → `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1).
- DIVU with `a` = 5, `b` = 0:
  - `done` arrives 1 cycle after `start`, with `div_zero` = 1, `hi` = 5, `lo` = 0xFFFFFFFF.
  - A following MULTU 3×4 clears `div_zero` and gives `lo` = 12.
- Abort and ignored start:
  - Start MULT 9×9, pulse `start` again at cycle 5 (must be ignored), then assert `reset` at cycle 10.
  - Required: `busy` = 0 and `hi` = `lo` = 0 immediately, with no `done`.
  - After release, MULT 9×9 gives `lo` = 81.
- WIDTH = 8, DIV with `a` = 0x80, `b` = 0xFF → `lo` = 0x80, `hi` = 0x00, `div_zero` = 0; latency 10 cycles.
